buffer_access_arbiter: RTL

- Sequences and shares the single-port byte-wide packet data buffer between the AHB-side requester (word/halfword/byte stores and reads) and the USB-side requester (single-byte packet stores and reads).
- Issues one byte access per cycle and tracks buffer occupancy.
- Services buffer-clear requests from the protocol controller.
- Sits between the AHB slave, the USB RX/TX packet engines, the protocol controller and the buffer storage.

---
 rtl/buffer_pkg.sv | 31 +++
 rtl/occupancy_counter.sv | 55 +++++
 rtl/buffer_access_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/buffer_pkg.sv
// Shared definitions for the packet buffer access arbiter.
//   - state_e      : arbiter FSM states
//   - requester_e  : which side owns the current buffer transfer
//   - size_to_bytes: decodes the AHB size field into a byte count
//   - DEFAULT_DEPTH / DEFAULT_OCC_W : default buffer capacity and occupancy width
package buffer_pkg;

  localparam int DEFAULT_DEPTH = 64;
  localparam int DEFAULT_OCC_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  typedef enum logic {
    REQ_AHB = 1'b0,
    REQ_USB = 1'b1
  } requester_e;

  // Size field 3 is a 4-byte access, the same as size 2.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      2'd0:    size_to_bytes = 3'd1;
      2'd1:    size_to_bytes = 3'd2;
      default: size_to_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Up/down/clear counter holding the number of bytes in the packet buffer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   inc_i      : one byte stored this cycle
//   dec_i      : one byte removed this cycle
//   clr_i      : buffer flushed this cycle (wins over inc/dec)
//   count_o    : current occupancy
module occupancy_counter
  import buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int OCC_W = DEFAULT_OCC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [OCC_W-1:0] count_o
);

  logic [OCC_W-1:0] count_q;
  logic [OCC_W-1:0] count_d;

  // NOTE: the default assignment first means every path assigns count_d, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

  // The arbiter's eligibility check must keep the count inside 0..DEPTH.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inc_i && !dec_i && !clr_i && (count_q >= OCC_W'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec_i && !inc_i && !clr_i && (count_q == '0)));

endmodule

// File: rtl/buffer_access_arbiter.sv
// Shares the single-port byte-wide packet buffer between the AHB side
// (1/2/4-byte stores and reads) and the USB side (single-byte stores and
// reads), one byte access per cycle, and services flush requests.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   ahb_req/ahb_write/ahb_size    : AHB request, direction, size code
//   ahb_done                      : pulse on the last byte of an AHB request
//   usb_req/usb_write             : USB single-byte request and direction
//   usb_done                      : pulse on the USB byte access
//   clear_req / clear_done        : flush request and completion pulse
//   buf_wen / buf_ren             : buffer write / read strobes
//   buf_src                       : data mux select, 0 = AHB, 1 = USB
//   buf_lane                      : AHB byte lane of this access (0 for USB)
//   occupancy                     : bytes currently held
module buffer_access_arbiter
  import buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int OCC_W = DEFAULT_OCC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ahb_req,
  input  logic             ahb_write,
  input  logic [1:0]       ahb_size,
  output logic             ahb_done,
  input  logic             usb_req,
  input  logic             usb_write,
  output logic             usb_done,
  input  logic             clear_req,
  output logic             clear_done,
  output logic             buf_wen,
  output logic             buf_ren,
  output logic             buf_src,
  output logic [1:0]       buf_lane,
  output logic [OCC_W-1:0] occupancy
);

  localparam logic [OCC_W:0] DEPTH_X = (OCC_W+1)'(DEPTH);

  state_e     state_q, state_d;
  requester_e src_q, src_d;
  requester_e last_q, last_d;     // requester served most recently
  logic       write_q, write_d;
  logic [2:0] nbytes_q, nbytes_d;
  logic [1:0] cnt_q, cnt_d;

  logic [OCC_W:0] occ_x;
  logic [2:0]     ahb_n;
  logic           ahb_ok;
  logic           usb_ok;
  logic           grant_usb;
  logic           last_byte;
  logic           occ_inc;
  logic           occ_dec;
  logic           occ_clr;

  // One extra bit so occupancy + 4 cannot wrap in the space check.
  assign occ_x = {1'b0, occupancy};
  assign ahb_n = size_to_bytes(ahb_size);

  assign ahb_ok = ahb_req && (ahb_write ? ((occ_x + (OCC_W+1)'(ahb_n)) <= DEPTH_X)
                                        : (occ_x >= (OCC_W+1)'(ahb_n)));
  assign usb_ok = usb_req && (usb_write ? (occ_x < DEPTH_X) : (occ_x != '0));

  // On a tie the side that was not served last wins.
  assign grant_usb = usb_ok && (!ahb_ok || (last_q == REQ_AHB));

  assign last_byte = ({1'b0, cnt_q} == (nbytes_q - 3'd1));

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    last_d     = last_q;
    write_d    = write_q;
    nbytes_d   = nbytes_q;
    cnt_d      = cnt_q;
    ahb_done   = 1'b0;
    usb_done   = 1'b0;
    clear_done = 1'b0;
    buf_wen    = 1'b0;
    buf_ren    = 1'b0;
    buf_src    = 1'b0;
    buf_lane   = 2'd0;
    occ_inc    = 1'b0;
    occ_dec    = 1'b0;
    occ_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
        end else if (ahb_ok || usb_ok) begin
          // Direction and size are captured here; later changes on the
          // request lines do not affect the running transfer.
          state_d  = XFER;
          cnt_d    = 2'd0;
          src_d    = grant_usb ? REQ_USB : REQ_AHB;
          last_d   = grant_usb ? REQ_USB : REQ_AHB;
          write_d  = grant_usb ? usb_write : ahb_write;
          nbytes_d = grant_usb ? 3'd1 : ahb_n;
        end
      end

      XFER: begin
        buf_wen  = write_q;
        buf_ren  = !write_q;
        buf_src  = (src_q == REQ_USB);
        buf_lane = (src_q == REQ_AHB) ? cnt_q : 2'd0;
        occ_inc  = write_q;
        occ_dec  = !write_q;
        if (last_byte) begin
          ahb_done = (src_q == REQ_AHB);
          usb_done = (src_q == REQ_USB);
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      CLEAR: begin
        clear_done = 1'b1;
        occ_clr    = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pointer resets to "USB served last" so AHB wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      src_q    <= REQ_AHB;
      last_q   <= REQ_USB;
      write_q  <= 1'b0;
      nbytes_q <= 3'd1;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      last_q   <= last_d;
      write_q  <= write_d;
      nbytes_q <= nbytes_d;
      cnt_q    <= cnt_d;
    end
  end

  occupancy_counter #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_occupancy (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (occ_inc),
    .dec_i   (occ_dec),
    .clr_i   (occ_clr),
    .count_o (occupancy)
  );

endmodule
